// File: rtl/his_reader_fsm_pkg.sv
// Shared definitions for the histogram readout path.
//   - default geometry (bin address width, pixels per bank, count width)
//   - readout state encoding
//   - address width helper: AW = log2(PIXEL_NUM) + NB
package his_reader_fsm_pkg;

  localparam int NB_DEF        = 4;
  localparam int PIXEL_NUM_DEF = 4;
  localparam int CW_DEF        = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_OUT  = 2'd2,
    ST_PK   = 2'd3
  } rd_state_e;

  function automatic int addr_w(input int nb, input int pixel_num);
    return $clog2(pixel_num) + nb;
  endfunction

endpackage

// File: rtl/his_peak_tracker.sv
// Running per-pixel peak of the histogram bins seen so far.
// Ports:
//   clk        clock
//   clear      synchronous clear of the tracked peak (bin 0, count 0)
//   update     present bin/count is a newly captured bin
//   bin        bin index of the captured bin
//   count      count of the captured bin
//   peak_bin   bin index of the current peak
//   peak_count count of the current peak
module his_peak_tracker #(
  parameter int NB = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          update,
  input  logic [NB-1:0] bin,
  input  logic [CW-1:0] count,
  output logic [NB-1:0] peak_bin,
  output logic [CW-1:0] peak_count
);

  logic [NB-1:0] peak_bin_q;
  logic [CW-1:0] peak_count_q;

  // Strict greater-than: bins arrive in ascending order, so a tie keeps the
  // lowest bin, and an all-zero pixel never moves off bin 0 / count 0.
  always_ff @(posedge clk) begin
    if (clear) begin
      peak_bin_q   <= '0;
      peak_count_q <= '0;
    end else if (update && (count > peak_count_q)) begin
      peak_bin_q   <= bin;
      peak_count_q <= count;
    end
  end

  assign peak_bin   = peak_bin_q;
  assign peak_count = peak_count_q;

endmodule

// File: rtl/his_reader_fsm.sv
// Histogram bank reader: on bank_ready, walks every pixel/bin of the
// completed bank in an external RAM, streams each bin out with valid/ready
// handshaking, clears each bin as it is read, and reports the per-pixel peak.
// Ports:
//   clk, res                 clock, synchronous active-high reset
//   bank_ready, bank_sel     completed-bank pulse and its bank index
//   ram_rd_en/bank/addr      RAM read request (addr = pixel*BIN_NUM + bin)
//   ram_rd_data              RAM read data, one cycle after ram_rd_en
//   ram_clr_en/addr          write-zero to the bank given by ram_rd_bank
//   out_valid/ready          bin stream handshake
//   out_pixel/bin/count/last bin stream payload (last = final bin of pixel)
//   peak_valid/pixel/bin/count  one-cycle per-pixel peak report
//   busy                     readout in progress
//   overrun                  sticky: bank_ready arrived while busy
module his_reader_fsm
  import his_reader_fsm_pkg::*;
#(
  parameter  int NB        = NB_DEF,
  parameter  int PIXEL_NUM = PIXEL_NUM_DEF,
  parameter  int CW        = CW_DEF,
  localparam int PW        = $clog2(PIXEL_NUM),
  localparam int AW        = addr_w(NB, PIXEL_NUM)
) (
  input  logic          clk,
  input  logic          res,
  input  logic          bank_ready,
  input  logic          bank_sel,
  output logic          ram_rd_en,
  output logic          ram_rd_bank,
  output logic [AW-1:0] ram_rd_addr,
  input  logic [CW-1:0] ram_rd_data,
  output logic          ram_clr_en,
  output logic [AW-1:0] ram_clr_addr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_pixel,
  output logic [NB-1:0] out_bin,
  output logic [CW-1:0] out_count,
  output logic          out_last,
  output logic          peak_valid,
  output logic [PW-1:0] peak_pixel,
  output logic [NB-1:0] peak_bin,
  output logic [CW-1:0] peak_count,
  output logic          busy,
  output logic          overrun
);

  localparam logic [NB-1:0] BIN_MAX = '1;
  localparam logic [PW-1:0] PIX_MAX = PW'(PIXEL_NUM - 1);

  rd_state_e     state_q, state_d;
  logic          bank_q, bank_d;
  logic [PW-1:0] pixel_q, pixel_d;
  logic [NB-1:0] bin_q, bin_d;
  // cap_q marks the first OUT cycle: the RAM word is on ram_rd_data right
  // now, so it is forwarded to out_count and registered at the same edge.
  // This keeps the rate at one bin per RD+OUT pair.
  logic          cap_q, cap_d;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d;
  logic          trk_clear;
  logic [NB-1:0] trk_bin;
  logic [CW-1:0] trk_count;

  // State register
  always_ff @(posedge clk) begin
    if (res) begin
      state_q   <= ST_IDLE;
      bank_q    <= 1'b0;
      pixel_q   <= '0;
      bin_q     <= '0;
      cap_q     <= 1'b0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bank_q    <= bank_d;
      pixel_q   <= pixel_d;
      bin_q     <= bin_d;
      cap_q     <= cap_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    bank_d    = bank_q;
    pixel_d   = pixel_q;
    bin_d     = bin_q;
    cap_d     = 1'b0;
    count_d   = cap_q ? ram_rd_data : count_q;
    overrun_d = overrun_q | (bank_ready && (state_q != ST_IDLE));
    trk_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bank_ready) begin
          bank_d    = bank_sel;
          pixel_d   = '0;
          bin_d     = '0;
          trk_clear = 1'b1;
          state_d   = ST_RD;
        end
      end
      ST_RD: begin
        cap_d   = 1'b1;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          if (bin_q == BIN_MAX) begin
            state_d = ST_PK;
          end else begin
            bin_d   = bin_q + NB'(1);
            state_d = ST_RD;
          end
        end
      end
      ST_PK: begin
        trk_clear = 1'b1;
        if (pixel_q == PIX_MAX) begin
          state_d = ST_IDLE;
        end else begin
          pixel_d = pixel_q + PW'(1);
          bin_d   = '0;
          state_d = ST_RD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  his_peak_tracker #(
    .NB (NB),
    .CW (CW)
  ) u_peak (
    .clk        (clk),
    .clear      (res | trk_clear),
    .update     (cap_q),
    .bin        (bin_q),
    .count      (ram_rd_data),
    .peak_bin   (trk_bin),
    .peak_count (trk_count)
  );

  // Output logic
  always_comb begin
    busy         = (state_q != ST_IDLE);
    overrun      = overrun_q;
    ram_rd_en    = (state_q == ST_RD);
    ram_rd_bank  = bank_q;
    ram_rd_addr  = {pixel_q, bin_q};
    ram_clr_en   = cap_q;
    ram_clr_addr = {pixel_q, bin_q};
    out_valid    = (state_q == ST_OUT);
    out_pixel    = pixel_q;
    out_bin      = bin_q;
    out_count    = cap_q ? ram_rd_data : count_q;
    out_last     = (state_q == ST_OUT) && (bin_q == BIN_MAX);
    peak_valid   = (state_q == ST_PK);
    peak_pixel   = pixel_q;
    peak_bin     = trk_bin;
    peak_count   = trk_count;
  end

endmodule

// File: tb/tb_his_reader_fsm.sv
module tb_his_reader_fsm;
  localparam int NB = 4, PIXEL_NUM = 4, CW = 8, PW = 2, AW = 6;
  localparam int BINS = 16, WORDS = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          res, bank_ready, bank_sel, out_ready;
  logic          ram_rd_en, ram_rd_bank, ram_clr_en;
  logic [AW-1:0] ram_rd_addr, ram_clr_addr;
  logic [CW-1:0] ram_rd_data;
  logic          out_valid, out_last, peak_valid, busy, overrun;
  logic [PW-1:0] out_pixel, peak_pixel;
  logic [NB-1:0] out_bin, peak_bin;
  logic [CW-1:0] out_count, peak_count;

  his_reader_fsm #(.NB(NB), .PIXEL_NUM(PIXEL_NUM), .CW(CW)) dut (
    .clk(clk), .res(res), .bank_ready(bank_ready), .bank_sel(bank_sel),
    .ram_rd_en(ram_rd_en), .ram_rd_bank(ram_rd_bank), .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data), .ram_clr_en(ram_clr_en), .ram_clr_addr(ram_clr_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_bin(out_bin), .out_count(out_count), .out_last(out_last),
    .peak_valid(peak_valid), .peak_pixel(peak_pixel), .peak_bin(peak_bin),
    .peak_count(peak_count), .busy(busy), .overrun(overrun)
  );

  // External histogram RAM: two banks; data appears one cycle after the read.
  // Idle cycles put random garbage on the data bus.
  logic [CW-1:0] mem [2][WORDS];
  logic [CW-1:0] snap [WORDS];
  always @(posedge clk)
    ram_rd_data <= ram_rd_en ? mem[ram_rd_bank][ram_rd_addr] : CW'($urandom);

  int n_checks = 0, n_err = 0;
  int ready_pct = 100;
  bit br_next = 0, bs_next = 0, res_next = 1;
  bit zero_chk = 0, mon = 0, stalled = 0;
  logic [63:0] stall_vec;
  logic [63:0] beat_q[$], peak_q[$];
  int exp_bank = 0;
  int clr_cnt[WORDS];
  int clr_total = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] beat_vec();
    return 64'({out_pixel, out_bin, out_count, out_last});
  endfunction

  function automatic logic [63:0] outs_vec();
    return 64'({busy, overrun, out_valid, out_last, out_pixel, out_bin, out_count,
                peak_valid, peak_pixel, peak_bin, peak_count, ram_rd_en, ram_rd_bank,
                ram_rd_addr, ram_clr_en, ram_clr_addr});
  endfunction

  // One clock: drive inputs for the next rising edge, then observe.
  task automatic cycle();
    logic [63:0] beat, exp;
    @(negedge clk);
    res        = res_next;
    bank_ready = br_next;
    bank_sel   = bs_next;
    br_next    = 1'b0;
    out_ready  = ($urandom_range(0, 99) < ready_pct);
    beat = beat_vec();
    if (zero_chk) chk("reset_outputs_zero", outs_vec(), 64'd0);
    if (ram_clr_en) begin
      chk("clear_bank", 64'(ram_rd_bank), 64'(exp_bank));
      clr_cnt[ram_clr_addr]++;
      clr_total++;
      mem[ram_rd_bank][ram_clr_addr] = '0;
    end
    if (mon) begin
      if (stalled) chk("stall_hold", {out_valid, beat[62:0]}, {1'b1, stall_vec[62:0]});
      stalled = 0;
      if (out_valid && out_ready) begin
        exp = (beat_q.size() > 0) ? beat_q.pop_front() : '1;
        chk("beat", beat, exp);
      end else if (out_valid) begin
        stalled   = 1;
        stall_vec = beat;
      end
      if (peak_valid) begin
        exp = (peak_q.size() > 0) ? peak_q.pop_front() : '1;
        chk("peak", 64'({peak_pixel, peak_bin, peak_count}), exp);
      end
    end
  endtask

  // Reference: bins stream pixel-major; peak is the first maximum, else bin 0/count 0.
  task automatic prep(input int bank);
    logic [CW-1:0] c, bc;
    int bb;
    beat_q.delete();
    peak_q.delete();
    for (int p = 0; p < PIXEL_NUM; p++) begin
      bc = '0; bb = 0;
      for (int b = 0; b < BINS; b++) begin
        c = mem[bank][p * BINS + b];
        beat_q.push_back(64'({PW'(p), NB'(b), c, (b == BINS - 1)}));
        if (c > bc) begin bc = c; bb = b; end
      end
      peak_q.push_back(64'({PW'(p), NB'(bb), bc}));
    end
    for (int a = 0; a < WORDS; a++) clr_cnt[a] = 0;
    clr_total = 0;
    exp_bank  = bank;
    stalled   = 0;
  endtask

  task automatic readout(input int bank, input int pct, input int ovr_at);
    bit done;
    int bad, nz;
    prep(bank);
    ready_pct = pct;
    mon = 1;
    br_next = 1'b1;
    bs_next = bank[0];
    cycle();
    done = 0;
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      if (cyc == ovr_at) begin br_next = 1'b1; bs_next = ~bank[0]; end
      cycle();
      if (beat_q.size() == 0 && peak_q.size() == 0 && busy == 1'b0) done = 1;
    end
    chk("readout_done", 64'(done), 64'd1);
    chk("beats_left", 64'(beat_q.size()), 64'd0);
    chk("peaks_left", 64'(peak_q.size()), 64'd0);
    chk("busy_end", 64'(busy), 64'd0);
    bad = 0; nz = 0;
    for (int a = 0; a < WORDS; a++) begin
      if (clr_cnt[a] != 1) bad++;
      if (mem[bank][a] != '0) nz++;
    end
    chk("clear_once_each", 64'(bad), 64'd0);
    chk("clear_total", 64'(clr_total), 64'(WORDS));
    chk("bank_zeroed", 64'(nz), 64'd0);
  endtask

  task automatic fill_random(input int bank);
    for (int a = 0; a < WORDS; a++) mem[bank][a] = CW'($urandom);
  endtask

  initial begin
    int k, mism;
    res = 1'b1; bank_ready = 1'b0; bank_sel = 1'b0; out_ready = 1'b1;
    ram_rd_data = '0;
    for (int a = 0; a < WORDS; a++) begin mem[0][a] = '0; mem[1][a] = '0; end

    // Power-up reset, outputs zero while held and after release.
    cycle();
    zero_chk = 1;
    cycle(); cycle();
    res_next = 0;
    cycle();
    zero_chk = 0;

    // Single bank with a tie in pixel 2 (bins 5 and 9 at 9, peak must be bin 5).
    for (int a = 0; a < WORDS; a++) mem[0][a] = 8'd1;
    mem[0][2 * BINS + 5] = 8'd9;
    mem[0][2 * BINS + 9] = 8'd9;
    readout(0, 100, -1);

    // Backpressure: ready low about 30% of cycles.
    fill_random(1);
    readout(1, 70, -1);

    // Overrun: second bank_ready 10 cycles in is dropped, bank 1 untouched.
    fill_random(0);
    fill_random(1);
    for (int a = 0; a < WORDS; a++) snap[a] = mem[1][a];
    readout(0, 100, 10);
    chk("overrun_set", 64'(overrun), 64'd1);
    cycle(); cycle(); cycle();
    chk("overrun_sticky", 64'(overrun), 64'd1);
    chk("overrun_idle", 64'(busy), 64'd0);
    mism = 0;
    for (int a = 0; a < WORDS; a++) if (mem[1][a] != snap[a]) mism++;
    chk("dropped_bank_untouched", 64'(mism), 64'd0);
    res_next = 1; cycle(); cycle();
    res_next = 0; cycle();
    chk("overrun_cleared", 64'(overrun), 64'd0);

    // Empty bank: every peak is bin 0, count 0.
    for (int a = 0; a < WORDS; a++) mem[0][a] = '0;
    readout(0, 100, -1);

    // Max count, no wrap.
    fill_random(1);
    for (int a = 0; a < WORDS; a++) if (mem[1][a] == 8'hFF) mem[1][a] = 8'hFE;
    mem[1][1 * BINS + 7] = 8'hFF;
    mem[1][3 * BINS + 0] = 8'hFF;
    readout(1, 60, -1);

    // Reset mid-readout, held 3 cycles; cleared prefix stays zero, rest intact.
    fill_random(0);
    for (int a = 0; a < WORDS; a++) snap[a] = mem[0][a];
    prep(0);
    ready_pct = 100;
    mon = 1;
    br_next = 1'b1; bs_next = 1'b0;
    cycle();
    for (int i = 0; i < 25; i++) cycle();
    mon = 0;
    res_next = 1;
    cycle();
    zero_chk = 1;
    cycle(); cycle();
    res_next = 0;
    cycle();
    zero_chk = 0;
    k = clr_total;
    chk("some_bins_cleared", 64'(k > 0 && k < WORDS), 64'd1);
    for (int i = 0; i < 20; i++) cycle();
    chk("no_clear_after_reset", 64'(clr_total), 64'(k));
    chk("idle_after_reset", 64'(busy), 64'd0);
    mism = 0;
    for (int a = 0; a < WORDS; a++)
      if (mem[0][a] != ((a < k) ? 8'd0 : snap[a])) mism++;
    chk("abandoned_bank_state", 64'(mism), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
